// File: rtl/ddr_channel_arb_if.sv
// ----------------------------------------------------------------------------
// ddr_channel_arb_if
//  Bundles the three request/response paths around the DDR channel arbiter:
//   - fetch path  : if_req_valid/index/ready, if_flush, if_op_done, if_rdata
//   - LSU path    : lsu_req_valid/we/index/wdata/wmask/ready, lsu_op_done,
//                   lsu_rdata
//   - DDR path    : ddr_req_valid/ready, ddr_we/index/wdata/wmask,
//                   ddr_resp_valid, ddr_rdata
//  modport master : the arbiter's view (drives DDR requests, grants, results)
//  modport slave  : the surrounding system's view (requesters + DDR controller)
// ----------------------------------------------------------------------------
interface ddr_channel_arb_if #(
    parameter int IDX_W    = 19,
    parameter int DATA_W   = 64,
    parameter int IF_BEATS = 8
);
    // fetch path
    logic                         if_req_valid;
    logic [IDX_W-1:0]             if_req_index;
    logic                         if_req_ready;
    logic                         if_flush;
    logic                         if_op_done;
    logic [IF_BEATS*DATA_W-1:0]   if_rdata;
    // LSU path
    logic                         lsu_req_valid;
    logic                         lsu_req_we;
    logic [IDX_W-1:0]             lsu_req_index;
    logic [DATA_W-1:0]            lsu_req_wdata;
    logic [DATA_W/8-1:0]          lsu_req_wmask;
    logic                         lsu_req_ready;
    logic                         lsu_op_done;
    logic [DATA_W-1:0]            lsu_rdata;
    // DDR path
    logic                         ddr_req_valid;
    logic                         ddr_req_ready;
    logic                         ddr_we;
    logic [IDX_W-1:0]             ddr_index;
    logic [DATA_W-1:0]            ddr_wdata;
    logic [DATA_W/8-1:0]          ddr_wmask;
    logic                         ddr_resp_valid;
    logic [DATA_W-1:0]            ddr_rdata;

    modport master (
        input  if_req_valid, if_req_index, if_flush,
        output if_req_ready, if_op_done, if_rdata,
        input  lsu_req_valid, lsu_req_we, lsu_req_index, lsu_req_wdata, lsu_req_wmask,
        output lsu_req_ready, lsu_op_done, lsu_rdata,
        output ddr_req_valid, ddr_we, ddr_index, ddr_wdata, ddr_wmask,
        input  ddr_req_ready, ddr_resp_valid, ddr_rdata
    );

    modport slave (
        output if_req_valid, if_req_index, if_flush,
        input  if_req_ready, if_op_done, if_rdata,
        output lsu_req_valid, lsu_req_we, lsu_req_index, lsu_req_wdata, lsu_req_wmask,
        input  lsu_req_ready, lsu_op_done, lsu_rdata,
        input  ddr_req_valid, ddr_we, ddr_index, ddr_wdata, ddr_wmask,
        output ddr_req_ready, ddr_resp_valid, ddr_rdata
    );
endinterface

// File: rtl/ddr_channel_arb.sv
// ----------------------------------------------------------------------------
// ddr_channel_arb
//  Shares one DDR channel between the instruction fetch path and the LSU.
//  Round-robin grant (LSU preferred after reset), one DDR beat outstanding.
//  A fetch is IF_BEATS sequential beats from a base index (index wraps modulo
//  2^IDX_W); an LSU access is a single read or write beat.
//  Ports:
//   clock    : clock
//   reset_n  : asynchronous active-low reset; abandons any operation at once
//   bus      : ddr_channel_arb_if.master (fetch, LSU and DDR paths)
//  Parameters must match those of the connected interface instance.
// ----------------------------------------------------------------------------
module ddr_channel_arb #(
    parameter int IDX_W    = 19,
    parameter int DATA_W   = 64,
    parameter int IF_BEATS = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    ddr_channel_arb_if.master   bus
);
    localparam int BEAT_W = (IF_BEATS > 1) ? $clog2(IF_BEATS) : 1;
    localparam int MASK_W = DATA_W / 8;
    localparam int LINE_W = IF_BEATS * DATA_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(IF_BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_IF_ISSUE  = 3'd1,
        ST_IF_WAIT   = 3'd2,
        ST_LSU_ISSUE = 3'd3,
        ST_LSU_WAIT  = 3'd4,
        ST_IF_DRAIN  = 3'd5
    } state_t;

    state_t              state_r;
    state_t              state_next_s;

    logic                prefer_lsu_r;   // 1: LSU wins a tie, 0: fetch wins
    logic [BEAT_W-1:0]   beat_r;
    logic [IDX_W-1:0]    idx_r;
    logic                we_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [MASK_W-1:0]   wmask_r;
    logic [LINE_W-1:0]   line_buf_r;     // beats of the fetch in progress
    logic [LINE_W-1:0]   if_rdata_r;     // last completed line
    logic                if_op_done_r;
    logic [DATA_W-1:0]   lsu_rdata_r;
    logic                lsu_op_done_r;

    logic                if_valid_eff_s;
    logic                grant_if_s;
    logic                grant_lsu_s;
    logic                ddr_req_valid_s;
    logic                beat_take_s;
    logic                lsu_take_s;
    logic [LINE_W-1:0]   line_merge_s;

    // A fetch request raised together with a flush is not a request.
    assign if_valid_eff_s = bus.if_req_valid & ~bus.if_flush;

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_lsu_s) begin
                    state_next_s = ST_LSU_ISSUE;
                end else if (grant_if_s) begin
                    state_next_s = ST_IF_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_IF_ISSUE: begin
                // A flush in the acceptance cycle still leaves a beat in flight.
                if (bus.if_flush) begin
                    state_next_s = bus.ddr_req_ready ? ST_IF_DRAIN : ST_IDLE;
                end else if (bus.ddr_req_ready) begin
                    state_next_s = ST_IF_WAIT;
                end else begin
                    state_next_s = ST_IF_ISSUE;
                end
            end
            ST_IF_WAIT: begin
                if (bus.ddr_resp_valid) begin
                    if (bus.if_flush || (beat_r == LAST_BEAT)) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_IF_ISSUE;
                    end
                end else if (bus.if_flush) begin
                    state_next_s = ST_IF_DRAIN;
                end else begin
                    state_next_s = ST_IF_WAIT;
                end
            end
            ST_IF_DRAIN: begin
                state_next_s = bus.ddr_resp_valid ? ST_IDLE : ST_IF_DRAIN;
            end
            ST_LSU_ISSUE: begin
                state_next_s = bus.ddr_req_ready ? ST_LSU_WAIT : ST_LSU_ISSUE;
            end
            ST_LSU_WAIT: begin
                state_next_s = bus.ddr_resp_valid ? ST_IDLE : ST_LSU_WAIT;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output / strobe decode from the current state.
    always_comb begin
        grant_if_s      = 1'b0;
        grant_lsu_s     = 1'b0;
        ddr_req_valid_s = 1'b0;
        beat_take_s     = 1'b0;
        lsu_take_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // reset_n gating keeps the accept pulses low while in reset
                if (reset_n) begin
                    grant_lsu_s = bus.lsu_req_valid & (~if_valid_eff_s | prefer_lsu_r);
                    grant_if_s  = if_valid_eff_s & (~bus.lsu_req_valid | ~prefer_lsu_r);
                end else begin
                    grant_lsu_s = 1'b0;
                    grant_if_s  = 1'b0;
                end
            end
            ST_IF_ISSUE, ST_LSU_ISSUE: begin
                ddr_req_valid_s = 1'b1;
            end
            ST_IF_WAIT: begin
                // a response arriving with a flush is consumed and discarded
                beat_take_s = bus.ddr_resp_valid & ~bus.if_flush;
            end
            ST_LSU_WAIT: begin
                lsu_take_s = bus.ddr_resp_valid;
            end
            default: begin
                ddr_req_valid_s = 1'b0;
            end
        endcase
    end

    // Insert the returning beat into its slot of the line being assembled.
    always_comb begin
        line_merge_s = line_buf_r;
        line_merge_s[int'(beat_r) * DATA_W +: DATA_W] = bus.ddr_rdata;
    end

    // Request latching, beat sequencing and result registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prefer_lsu_r  <= 1'b1;
            beat_r        <= '0;
            idx_r         <= '0;
            we_r          <= 1'b0;
            wdata_r       <= '0;
            wmask_r       <= '0;
            line_buf_r    <= '0;
            if_rdata_r    <= '0;
            if_op_done_r  <= 1'b0;
            lsu_rdata_r   <= '0;
            lsu_op_done_r <= 1'b0;
        end else begin
            if (grant_if_s) begin
                prefer_lsu_r <= 1'b1;
                beat_r       <= '0;
                idx_r        <= bus.if_req_index;
                we_r         <= 1'b0;
                wdata_r      <= '0;
                wmask_r      <= '0;
            end else if (grant_lsu_s) begin
                prefer_lsu_r <= 1'b0;
                idx_r        <= bus.lsu_req_index;
                we_r         <= bus.lsu_req_we;
                wdata_r      <= bus.lsu_req_wdata;
                wmask_r      <= bus.lsu_req_wmask;
            end else if (beat_take_s) begin
                // index wraps silently at 2^IDX_W
                idx_r      <= idx_r + IDX_W'(1'b1);
                beat_r     <= beat_r + BEAT_W'(1'b1);
                line_buf_r <= line_merge_s;
                if (beat_r == LAST_BEAT) begin
                    if_rdata_r <= line_merge_s;
                end else begin
                    if_rdata_r <= if_rdata_r;
                end
            end else begin
                beat_r <= beat_r;
            end

            if_op_done_r  <= beat_take_s & (beat_r == LAST_BEAT);
            lsu_op_done_r <= lsu_take_s;
            if (lsu_take_s && !we_r) begin
                lsu_rdata_r <= bus.ddr_rdata;
            end else begin
                lsu_rdata_r <= lsu_rdata_r;
            end
        end
    end

    assign bus.if_req_ready  = grant_if_s;
    assign bus.lsu_req_ready = grant_lsu_s;
    assign bus.ddr_req_valid = ddr_req_valid_s;
    assign bus.ddr_we        = ddr_req_valid_s & we_r;
    assign bus.ddr_index     = idx_r;
    assign bus.ddr_wdata     = wdata_r;
    assign bus.ddr_wmask     = wmask_r;
    assign bus.if_op_done    = if_op_done_r;
    assign bus.if_rdata      = if_rdata_r;
    assign bus.lsu_op_done   = lsu_op_done_r;
    assign bus.lsu_rdata     = lsu_rdata_r;

endmodule
